// File: rtl/sa_row_feeder_pkg.sv
// Shared defaults, FSM state encoding and width helper for the systolic-array row feeder.
package sa_row_feeder_pkg;

    localparam int unsigned DAT_W_DEF  = 16;
    localparam int unsigned DAT_D_DEF  = 48;
    localparam int unsigned BLOCKS_DEF = 3;
    localparam int unsigned GAP_DEF    = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRIME    = 3'd1,
        ST_STREAM   = 3'd2,
        ST_WAIT_FIN = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5
    } feed_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sa_feed_cnt.sv
// Loadable down-counter that saturates at zero and flags its terminal count.
module sa_feed_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/sa_row_feeder.sv
// Streams mem rows into comb_SA as BLOCKS blocks of ROWS rows, collecting each block's rank flag.
module sa_row_feeder
    import sa_row_feeder_pkg::*;
#(
    parameter int unsigned DAT_W  = DAT_W_DEF,
    parameter int unsigned DAT_D  = DAT_D_DEF,
    parameter int unsigned BLOCKS = BLOCKS_DEF,
    parameter int unsigned ROWS   = DAT_D / BLOCKS,
    parameter int unsigned GAP    = GAP_DEF,
    parameter int unsigned ADDR_W = idx_w(DAT_D)
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     go,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [BLOCKS-1:0]        blk_full_rank,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_rden,
    input  logic [DAT_W-1:0]         mem_q,
    output logic                     sa_start,
    output logic                     sa_valid,
    output logic [DAT_W-1:0]         sa_data,
    input  logic                     sa_finish,
    input  logic                     sa_r_A_and,
    output feed_state_e              dbg_state,
    output logic [idx_w(GAP)-1:0]    dbg_gap_left
);

    localparam int unsigned ROW_W = idx_w(ROWS);
    localparam int unsigned GAP_W = idx_w(GAP);
    localparam int unsigned BLK_W = idx_w(BLOCKS);

    feed_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rden_q, rden_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [BLOCKS-1:0] rank_q, rank_d;

    logic              row_load, row_dec, row_tc;
    logic [ROW_W-1:0]  row_cnt;
    logic              gap_load, gap_dec, gap_tc;
    logic [GAP_W-1:0]  gap_cnt;

    sa_feed_cnt #(.W(ROW_W)) u_row_cnt (
        .clk        (clk),
        .rst_b      (rst_b),
        .load_i     (row_load),
        .load_val_i (ROW_W'(ROWS - 1)),
        .dec_i      (row_dec),
        .cnt_o      (row_cnt),
        .tc_o       (row_tc)
    );

    sa_feed_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .rst_b      (rst_b),
        .load_i     (gap_load),
        .load_val_i (GAP_W'(GAP - 1)),
        .dec_i      (gap_dec),
        .cnt_o      (gap_cnt),
        .tc_o       (gap_tc)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rden_d   = rden_q;
        blk_d    = blk_q;
        rank_d   = rank_q;
        row_load = 1'b0;
        row_dec  = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            rden_d  = 1'b0;
            blk_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go && !abort) begin
                        state_d = ST_PRIME;
                        rank_d  = '0;
                        blk_d   = '0;
                        addr_d  = '0;
                        rden_d  = 1'b1;
                    end
                end
                ST_PRIME: begin
                    // First row's read is in flight; the second row's address goes out now.
                    state_d  = ST_STREAM;
                    row_load = 1'b1;
                    rden_d   = (ROWS > 1);
                    if (ROWS > 1) addr_d = addr_q + ADDR_W'(1);
                end
                ST_STREAM: begin
                    row_dec = 1'b1;
                    if (row_cnt > ROW_W'(1)) addr_d = addr_q + ADDR_W'(1);
                    else                     rden_d = 1'b0;
                    if (row_tc) state_d = ST_WAIT_FIN;
                end
                ST_WAIT_FIN: begin
                    if (sa_finish) begin
                        rank_d[blk_q] = sa_r_A_and;
                        if (blk_q == BLK_W'(BLOCKS - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d  = ST_GAP;
                            blk_d    = blk_q + BLK_W'(1);
                            addr_d   = addr_q + ADDR_W'(1);
                            gap_load = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    gap_dec = 1'b1;
                    if (gap_tc) begin
                        state_d  = ST_STREAM;
                        row_load = 1'b1;
                        rden_d   = (ROWS > 1);
                        if (ROWS > 1) addr_d = addr_q + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                    rden_d  = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rden_q  <= 1'b0;
            blk_q   <= '0;
            rank_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rden_q  <= rden_d;
            blk_q   <= blk_d;
            rank_q  <= rank_d;
        end
    end

    // The next block's address is already parked on mem_addr during GAP; the read fires on the last cycle.
    assign mem_rden      = rden_q | ((state_q == ST_GAP) && gap_tc);
    assign mem_addr      = addr_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign sa_valid      = (state_q == ST_STREAM);
    assign sa_start      = sa_valid && (row_cnt == ROW_W'(ROWS - 1));
    assign sa_data       = sa_valid ? mem_q : '0;
    assign blk_full_rank = rank_q;
    assign dbg_state     = state_q;
    assign dbg_gap_left  = gap_cnt;

endmodule

// File: tb/tb_sa_row_feeder.sv
// Self-checking bench for sa_row_feeder: memory model, comb_SA handshake driver and block-level reference.
module tb_sa_row_feeder;
    import sa_row_feeder_pkg::*;

    localparam int DAT_W  = 16;
    localparam int DAT_D  = 48;
    localparam int BLOCKS = 3;
    localparam int ROWS   = 16;
    localparam int GAP    = 10;
    localparam int ADDR_W = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_b, go, abort, sa_finish, sa_r_A_and;
    logic              busy, done, mem_rden, sa_start, sa_valid;
    logic [BLOCKS-1:0] blk_full_rank;
    logic [ADDR_W-1:0] mem_addr;
    logic [DAT_W-1:0]  mem_q, sa_data;
    feed_state_e       dbg_state;
    logic [3:0]        dbg_gap_left;

    sa_row_feeder #(
        .DAT_W(DAT_W), .DAT_D(DAT_D), .BLOCKS(BLOCKS), .ROWS(ROWS), .GAP(GAP), .ADDR_W(ADDR_W)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .go            (go),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .blk_full_rank (blk_full_rank),
        .mem_addr      (mem_addr),
        .mem_rden      (mem_rden),
        .mem_q         (mem_q),
        .sa_start      (sa_start),
        .sa_valid      (sa_valid),
        .sa_data       (sa_data),
        .sa_finish     (sa_finish),
        .sa_r_A_and    (sa_r_A_and),
        .dbg_state     (dbg_state),
        .dbg_gap_left  (dbg_gap_left)
    );

    // ---------------- registered-read memory model ----------------
    logic [DAT_W-1:0] mem_m [DAT_D];
    int oob_cnt = 0;
    initial mem_q = '0;
    always @(posedge clk) begin
        if (mem_rden) begin
            if (int'(mem_addr) < DAT_D) mem_q <= mem_m[mem_addr];
            else                        oob_cnt <= oob_cnt + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [BLOCKS-1:0] exp_rank;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill_mem(input bit linear);
        for (int k = 0; k < DAT_D; k++) mem_m[k] = linear ? DAT_W'(k) : DAT_W'($urandom);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, dbg_state, ST_IDLE);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_rden"}, mem_rden, 1'b0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_start"}, sa_start, 1'b0);
        check({tag, "_valid"}, sa_valid, 1'b0);
        check({tag, "_data"}, sa_data, 0);
    endtask

    // Pulse go in IDLE; lands in the sa_start cycle two cycles later.
    task automatic start_run();
        go = 1'b1;
        tick();
        go = 1'b0;
        exp_rank = '0;
        check("prime_busy", busy, 1'b1);
        check("prime_addr", mem_addr, 0);
        check("prime_rden", mem_rden, 1'b1);
        check("prime_valid", sa_valid, 1'b0);
        check("rank_clear", blk_full_rank, 0);
        tick();
        check("latency_start", sa_start, 1'b1);
    endtask

    // Check one block's rows; optionally inject go and a spurious sa_finish mid-stream.
    task automatic run_stream(input int b, input bit inject);
        logic [DAT_W-1:0] exp_q[$];
        int n;
        for (int k = 0; k < ROWS; k++) exp_q.push_back(mem_m[b*ROWS + k]);
        n = 0;
        while (sa_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("start_seen", sa_start, 1'b1);
        for (int r = 0; r < ROWS; r++) begin
            check("valid", sa_valid, 1'b1);
            check("start_row", sa_start, (r == 0));
            check("data", sa_data, exp_q.pop_front());
            check("addr", mem_addr, b*ROWS + ((r < ROWS-1) ? r+1 : ROWS-1));
            check("rden", mem_rden, (r < ROWS-1));
            check("rank_hold", blk_full_rank, exp_rank);
            go         = inject && (r == 4);
            sa_finish  = inject && (r == 7);
            sa_r_A_and = inject;
            tick();
        end
        go        = 1'b0;
        sa_finish = 1'b0;
        check("valid_end", sa_valid, 1'b0);
        check("busy_wait", busy, 1'b1);
    endtask

    // Return sa_finish after a random delay, then check gap timing or the done pulse.
    task automatic finish_block(input int b, input bit flag, input bit go_in_wait);
        int d;
        int n;
        d = $urandom_range(go_in_wait ? 1 : 0, 4);
        for (int i = 0; i < d; i++) begin
            check("wait_state", dbg_state, ST_WAIT_FIN);
            check("wait_valid", sa_valid, 1'b0);
            go         = go_in_wait && (i == 0);
            sa_r_A_and = 1'($urandom_range(0, 1));
            tick();
        end
        go         = 1'b0;
        sa_finish  = 1'b1;
        sa_r_A_and = flag;
        tick();
        sa_finish  = 1'b0;
        sa_r_A_and = 1'($urandom_range(0, 1));
        exp_rank[b] = flag;
        check("rank", blk_full_rank, exp_rank);
        if (b == BLOCKS-1) begin
            check("done", done, 1'b1);
            check("busy_in_done", busy, 1'b1);
            tick();
            check("done_pulse", done, 1'b0);
            check("busy_fall", busy, 1'b0);
            check("back_idle", dbg_state, ST_IDLE);
            check("rank_final", blk_full_rank, exp_rank);
        end else begin
            n = 1;
            while (sa_start !== 1'b1 && n < 40) begin
                check("gap_valid", sa_valid, 1'b0);
                check("gap_rden", mem_rden, (n == GAP));
                if (n <= GAP) check("gap_left", dbg_gap_left, GAP - n);
                if (n == GAP) check("gap_addr", mem_addr, (b+1)*ROWS);
                tick();
                n++;
            end
            check("finish_to_start", n, GAP + 1);
        end
    endtask

    task automatic full_run(input logic [BLOCKS-1:0] flags, input bit inject);
        start_run();
        for (int b = 0; b < BLOCKS; b++) begin
            run_stream(b, inject && (b == 1));
            finish_block(b, flags[b], inject && (b == 1));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int starts;
        rst_b = 1'b0; go = 1'b0; abort = 1'b0; sa_finish = 1'b0; sa_r_A_and = 1'b0;
        exp_rank = '0;
        fill_mem(1'b1);
        repeat (3) tick();
        check_idle_outputs("por");
        check("por_rank", blk_full_rank, 0);
        rst_b = 1'b1;
        tick();

        // Reset held three cycles in the middle of block 0.
        start_run();
        repeat (5) tick();
        check("pre_reset_stream", sa_valid, 1'b1);
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle_outputs("rst_mid");
            check("rst_mid_rank", blk_full_rank, 0);
        end
        rst_b = 1'b1;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sa_start === 1'b1 || sa_valid === 1'b1) starts++;
        end
        check("no_start_after_reset", starts, 0);

        // Nominal run, mem row k = k, rank flags 1,0,1.
        full_run(3'b101, 1'b0);
        check("rank_101", blk_full_rank, 3'b101);

        // Random content and flags; go and spurious sa_finish injected in block 1.
        fill_mem(1'b0);
        full_run(BLOCKS'($urandom), 1'b1);

        // Abort in WAIT_FIN of block 1.
        start_run();
        run_stream(0, 1'b0);
        finish_block(0, 1'b1, 1'b0);
        run_stream(1, 1'b0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle_outputs("abort");
        check("abort_rank_held", blk_full_rank, 3'b001);
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) starts++;
            tick();
        end
        check("abort_no_done", starts, 0);

        // abort and go together in IDLE: abort wins.
        go = 1'b1; abort = 1'b1;
        tick();
        go = 1'b0; abort = 1'b0;
        check("abort_go_idle", dbg_state, ST_IDLE);
        check("abort_go_busy", busy, 1'b0);
        tick();

        // Fresh go restarts from address 0.
        full_run(BLOCKS'($urandom), 1'b0);
        fill_mem(1'b0);
        full_run(BLOCKS'($urandom), 1'b0);

        check("mem_addr_in_range", oob_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
